// File: rtl/pac_move_sched.sv
// Movement scheduler for the Pac-Man sprite: merges keypad/keyboard direction
// commands into a small FIFO and, one per game tick, checks and commits moves.
module pac_move_sched #(
   parameter int DEPTH = 4,
   parameter int STEP  = 32,
   parameter int COLS  = 20,
   parameter int ROWS  = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kp_valid,
   input  logic [1:0] kp_dir,
   input  logic       kb_valid,
   input  logic [1:0] kb_dir,
   input  logic       game_tick,
   output logic       map_req,
   output logic [8:0] map_addr,
   input  logic       map_ack,
   input  logic       map_wall,
   output logic [9:0] pac_x,
   output logic [8:0] pac_y,
   output logic [1:0] facing,
   output logic       moved,
   output logic       blocked,
   output logic [7:0] drop_cnt,
   output logic [1:0] state_dbg
);

   localparam int PW        = $clog2(DEPTH);
   localparam int CW        = PW + 1;
   localparam int START_COL = 10;
   localparam int START_ROW = 7;

   typedef enum logic [1:0] {IDLE, CHECK, REQ, COMMIT} state_t;

   state_t        state, state_nxt;
   logic [1:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, kp_wr_ptr;
   logic [CW-1:0] count, space;
   logic          pop, kb_acc, kp_acc;
   logic [1:0]    n_drop;
   logic [8:0]    drop_sum;
   logic [1:0]    cmd_dir;
   logic          rej, oob;
   logic [4:0]    col, tgt_col;
   logic [3:0]    row, tgt_row;

   assign col       = pac_x[9:5];
   assign row       = pac_y[8:5];
   assign state_dbg = state;

   // Map lookup handshake: map_req is high for the whole REQ state with
   // map_addr frozen; the cycle map_ack is sampled ends REQ, so map_req falls
   // on the following cycle. map_wall is only looked at alongside map_ack.
   assign map_req = (state == REQ);

   // A pop frees a slot in the same cycle; keyboard wins the first free slot.
   always_comb begin
      space     = CW'(DEPTH) - count + CW'(pop);
      kb_acc    = kb_valid && (space != '0);
      kp_acc    = kp_valid && (space > CW'(kb_acc));
      kp_wr_ptr = wr_ptr + PW'(kb_acc);
      n_drop    = 2'(kb_valid && !kb_acc) + 2'(kp_valid && !kp_acc);
      drop_sum  = {1'b0, drop_cnt} + 9'(n_drop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         wr_ptr   <= wr_ptr + PW'(kb_acc) + PW'(kp_acc);
         rd_ptr   <= rd_ptr + PW'(pop);
         count    <= count + CW'(kb_acc) + CW'(kp_acc) - CW'(pop);
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (kb_acc) mem[wr_ptr] <= kb_dir;
      if (kp_acc) mem[kp_wr_ptr] <= kp_dir;
   end

   // Edge tiles are caught by compare rather than letting col/row wrap.
   always_comb begin
      tgt_col = col;
      tgt_row = row;
      oob     = 1'b0;
      case (cmd_dir)
         2'b00: begin
            oob     = (row == 4'd0);
            tgt_row = row - 4'd1;
         end
         2'b01: begin
            oob     = (row >= 4'(ROWS - 1));
            tgt_row = row + 4'd1;
         end
         2'b10: begin
            oob     = (col == 5'd0);
            tgt_col = col - 5'd1;
         end
         default: begin
            oob     = (col >= 5'(COLS - 1));
            tgt_col = col + 5'd1;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (game_tick && (count != '0)) begin
               pop       = 1'b1;
               state_nxt = CHECK;
            end
         end
         CHECK:   state_nxt = oob ? COMMIT : REQ;
         REQ:     if (map_ack) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pac_x    <= 10'(START_COL * STEP + STEP / 2);
         pac_y    <= 9'(START_ROW * STEP + STEP / 2);
         facing   <= 2'b00;
         moved    <= 1'b0;
         blocked  <= 1'b0;
         map_addr <= '0;
         cmd_dir  <= 2'b00;
         rej      <= 1'b0;
      end else begin
         moved   <= 1'b0;
         blocked <= 1'b0;
         if (pop) cmd_dir <= mem[rd_ptr];
         case (state)
            CHECK: begin
               rej <= oob;
               if (!oob) map_addr <= {tgt_row, tgt_col};
            end
            REQ: begin
               if (map_ack) rej <= map_wall;
            end
            COMMIT: begin
               facing <= cmd_dir;
               if (!rej) begin
                  case (cmd_dir)
                     2'b00:   pac_y <= pac_y - 9'(STEP);
                     2'b01:   pac_y <= pac_y + 9'(STEP);
                     2'b10:   pac_x <= pac_x - 10'(STEP);
                     default: pac_x <= pac_x + 10'(STEP);
                  endcase
                  moved <= 1'b1;
               end else begin
                  blocked <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pac_move_sched.sv
// Bench for pac_move_sched: directed scenarios plus randomized traffic checked
// against a tile-level model (command queue, col/row position, wall map).
module tb_pac_move_sched;

   localparam int DEPTH = 4;
   localparam int STEP  = 32;
   localparam int COLS  = 20;
   localparam int ROWS  = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       kp_valid, kb_valid, game_tick, map_ack, map_wall;
   logic [1:0] kp_dir, kb_dir;
   logic       map_req, moved, blocked;
   logic [8:0] map_addr;
   logic [9:0] pac_x;
   logic [8:0] pac_y;
   logic [1:0] facing, state_dbg;
   logic [7:0] drop_cnt;

   always #5 clk = ~clk;

   pac_move_sched #(.DEPTH(DEPTH), .STEP(STEP), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst(rst),
      .kp_valid(kp_valid), .kp_dir(kp_dir),
      .kb_valid(kb_valid), .kb_dir(kb_dir),
      .game_tick(game_tick),
      .map_req(map_req), .map_addr(map_addr), .map_ack(map_ack), .map_wall(map_wall),
      .pac_x(pac_x), .pac_y(pac_y), .facing(facing),
      .moved(moved), .blocked(blocked), .drop_cnt(drop_cnt),
      .state_dbg(state_dbg)
   );

   typedef struct packed {
      logic [3:0] req_cycles;
      logic [8:0] addr;
      logic [3:0] n_moved;
      logic [3:0] n_blocked;
      logic [4:0] pulse_at;
      logic [9:0] x;
      logic [8:0] y;
      logic [1:0] facing;
   } move_t;

   logic [1:0] exp_q[$];
   int         m_col, m_row, m_drops;
   logic [1:0] m_facing;
   bit         wall_map[ROWS][COLS];
   int         n_vec = 0;
   int         n_err = 0;

   // ---------------- reference model ----------------
   function automatic void model_reset();
      exp_q.delete();
      m_col = 10; m_row = 7; m_facing = 2'b00; m_drops = 0;
   endfunction

   function automatic void model_push(input bit v, input logic [1:0] d);
      if (v) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else if (m_drops < 255) m_drops++;
      end
   endfunction

   function automatic void model_target(input logic [1:0] d, output int nc, output int nr);
      nc = m_col; nr = m_row;
      case (d)
         2'b00: nr = m_row - 1;
         2'b01: nr = m_row + 1;
         2'b10: nc = m_col - 1;
         default: nc = m_col + 1;
      endcase
   endfunction

   function automatic bit in_maze(input int c, input int r);
      return (c >= 0) && (c < COLS) && (r >= 0) && (r < ROWS);
   endfunction

   function automatic bit peek_wall();
      int nc, nr;
      if (exp_q.size() == 0) return 1'b0;
      model_target(exp_q[0], nc, nr);
      return in_maze(nc, nr) ? wall_map[nr][nc] : 1'b0;
   endfunction

   // Tick outcome: lookup cycles, address, pulses and when the pulse shows
   // (cycles after the tick edge), plus resulting position and facing.
   function automatic move_t model_tick(input int lat, input bit wall);
      move_t      e;
      int         nc, nr;
      bit         ok;
      logic [1:0] d;
      e = '0;
      e.pulse_at = 5'd31;
      if (exp_q.size() != 0) begin
         d = exp_q.pop_front();
         model_target(d, nc, nr);
         ok = in_maze(nc, nr);
         m_facing = d;
         if (!ok) begin
            e.n_blocked = 4'd1;
            e.pulse_at  = 5'd2;
         end else begin
            e.req_cycles = 4'(lat);
            e.addr       = 9'(nr * 32 + nc);
            e.pulse_at   = 5'(lat + 2);
            if (wall) e.n_blocked = 4'd1;
            else begin
               e.n_moved = 4'd1;
               m_col = nc; m_row = nr;
            end
         end
      end
      e.x      = 10'(m_col * STEP + STEP / 2);
      e.y      = 9'(m_row * STEP + STEP / 2);
      e.facing = m_facing;
      return e;
   endfunction

   function automatic string fmt(input move_t m);
      return $sformatf("req=%0d addr=%0d mv=%0d bl=%0d at=%0d x=%0d y=%0d f=%0d",
                       m.req_cycles, m.addr, m.n_moved, m.n_blocked, m.pulse_at, m.x, m.y, m.facing);
   endfunction

   // ---------------- drivers ----------------
   task automatic apply_reset();
      kp_valid = 0; kb_valid = 0; kp_dir = 0; kb_dir = 0;
      game_tick = 0; map_ack = 0; map_wall = 0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   task automatic push(input bit kbv, input logic [1:0] kbd, input bit kpv, input logic [1:0] kpd);
      kb_valid = kbv; kb_dir = kbd; kp_valid = kpv; kp_dir = kpd;
      @(negedge clk);
      kb_valid = 0; kp_valid = 0;
      model_push(kbv, kbd);
      model_push(kpv, kpd);
   endtask

   // Tick (optionally with a same-cycle keyboard push), then act as the map
   // responder: ack after lat observed map_req cycles, bounded window.
   task automatic do_tick(input int lat, input bit wall, input bit tick_in_req, input bit noise,
                          input bit kbv, input logic [1:0] kbd, output move_t o);
      o = '0;
      o.pulse_at = 5'd31;
      game_tick = 1; kb_valid = kbv; kb_dir = kbd;
      @(negedge clk);
      game_tick = 0; kb_valid = 0;
      for (int k = 0; k < lat + 6; k++) begin
         map_ack = 0;
         if (map_req) begin
            if (o.req_cycles == 0) o.addr = map_addr;
            o.req_cycles++;
         end
         if (moved) o.n_moved++;
         if (blocked) o.n_blocked++;
         if ((moved || blocked) && o.pulse_at == 5'd31) o.pulse_at = 5'(k);
         if (map_req && o.req_cycles == 4'(lat)) begin
            map_ack = 1; map_wall = wall;
         end else begin
            map_ack  = noise && !map_req && ($urandom_range(0, 1) == 1);
            map_wall = 1'($urandom_range(0, 1));
         end
         game_tick = tick_in_req && map_req && (o.req_cycles == 4'd1);
         @(negedge clk);
      end
      map_ack = 0; game_tick = 0;
      o.x = pac_x; o.y = pac_y; o.facing = facing;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      move_t o, e;
      apply_reset();
      n_vec++; if (pac_x !== 10'd336) begin n_err++; $display("FAIL rst_pac_x: got %0d want 336", pac_x); end
      n_vec++; if (pac_y !== 9'd240) begin n_err++; $display("FAIL rst_pac_y: got %0d want 240", pac_y); end
      n_vec++; if (facing !== 2'b00) begin n_err++; $display("FAIL rst_facing: got %b want 00", facing); end
      n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
      n_vec++; if (map_req !== 1'b0) begin n_err++; $display("FAIL rst_map_req: got %b want 0", map_req); end
      n_vec++; if (map_addr !== 9'd0) begin n_err++; $display("FAIL rst_map_addr: got %0d want 0", map_addr); end
      n_vec++; if (moved !== 1'b0 || blocked !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got %b%b want 00", moved, blocked); end
      n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
      do_tick(2, 0, 0, 1, 0, 2'b00, o);
      e = model_tick(2, 0);
      n_vec++; if (o !== e) begin n_err++; $display("FAIL empty_tick: got %s want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_right_move();
      move_t o, e;
      apply_reset();
      push(1, 2'b11, 0, 2'b00);
      do_tick(1, 0, 0, 0, 0, 2'b00, o);
      e = model_tick(1, 0);
      n_vec++; if (o !== e) begin n_err++; $display("FAIL right_move: got %s want %s", fmt(o), fmt(e)); end
      n_vec++; if (o.addr !== 9'd235 || o.x !== 10'd368) begin n_err++; $display("FAIL right_addr: got addr=%0d x=%0d want 235/368", o.addr, o.x); end
   endtask

   task automatic test_left_edge();
      move_t o, e;
      int    lat;
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         push(0, 2'b00, 1, 2'b10);
         lat = $urandom_range(1, 4);
         do_tick(lat, 0, 0, 1, 0, 2'b00, o);
         e = model_tick(lat, 0);
         n_vec++; if (o !== e) begin n_err++; $display("FAIL left_step%0d: got %s want %s", i, fmt(o), fmt(e)); end
      end
      n_vec++; if (pac_x !== 10'd16) begin n_err++; $display("FAIL left_edge_x: got %0d want 16", pac_x); end
   endtask

   task automatic test_dual_source();
      move_t o, e;
      apply_reset();
      push(1, 2'b00, 1, 2'b01);
      for (int i = 0; i < 2; i++) begin
         do_tick(2, 0, 0, 0, 0, 2'b00, o);
         e = model_tick(2, 0);
         n_vec++; if (o !== e) begin n_err++; $display("FAIL dual_src%0d: got %s want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_overflow();
      move_t o, e;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 1) == 1) push(1, 2'($urandom_range(0, 3)), 0, 2'b00);
         else                           push(0, 2'b00, 1, 2'($urandom_range(0, 3)));
      end
      n_vec++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL overflow_drop: got %0d want 2", drop_cnt); end
      for (int i = 0; i < 5; i++) begin
         do_tick(1, 0, 0, 0, 0, 2'b00, o);
         e = model_tick(1, 0);
         n_vec++; if (o !== e) begin n_err++; $display("FAIL overflow_pop%0d: got %s want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_full_pop_push();
      move_t      o, e;
      logic [1:0] d;
      apply_reset();
      push(1, 2'($urandom_range(0, 3)), 1, 2'($urandom_range(0, 3)));
      push(1, 2'($urandom_range(0, 3)), 1, 2'($urandom_range(0, 3)));
      d = 2'($urandom_range(0, 3));
      do_tick(2, 0, 0, 0, 1, d, o);
      e = model_tick(2, 0);
      model_push(1, d);
      n_vec++; if (o !== e) begin n_err++; $display("FAIL popush_tick: got %s want %s", fmt(o), fmt(e)); end
      n_vec++; if (drop_cnt !== 8'(m_drops)) begin n_err++; $display("FAIL popush_drop: got %0d want %0d", drop_cnt, m_drops); end
      for (int i = 0; i < 4; i++) begin
         do_tick(1, 0, 0, 0, 0, 2'b00, o);
         e = model_tick(1, 0);
         n_vec++; if (o !== e) begin n_err++; $display("FAIL popush_drain%0d: got %s want %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_wall_delay();
      move_t o, e;
      apply_reset();
      push(1, 2'b00, 0, 2'b00);
      push(0, 2'b00, 1, 2'b11);
      do_tick(5, 1, 1, 1, 0, 2'b00, o);
      e = model_tick(5, 1);
      n_vec++; if (o !== e) begin n_err++; $display("FAIL wall_up: got %s want %s", fmt(o), fmt(e)); end
      do_tick(2, 0, 0, 0, 0, 2'b00, o);
      e = model_tick(2, 0);
      n_vec++; if (o !== e) begin n_err++; $display("FAIL wall_next: got %s want %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_drop_saturate();
      apply_reset();
      for (int i = 0; i < 130; i++) push(1, 2'($urandom_range(0, 3)), 1, 2'($urandom_range(0, 3)));
      n_vec++; if (drop_cnt !== 8'(m_drops) || drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_sat: got %0d want %0d", drop_cnt, m_drops); end
   endtask

   task automatic test_random();
      move_t      o, e;
      int         lat;
      bit         wall, kbv;
      logic [1:0] d;
      apply_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            wall_map[r][c] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            push(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         end else begin
            lat  = $urandom_range(1, 6);
            wall = peek_wall();
            kbv  = 1'($urandom_range(0, 1));
            d    = 2'($urandom_range(0, 3));
            do_tick(lat, wall, 1'($urandom_range(0, 1)), 1, kbv, d, o);
            e = model_tick(lat, wall);
            model_push(kbv, d);
            n_vec++; if (o !== e) begin n_err++; $display("FAIL rand_tick%0d: got %s want %s", i, fmt(o), fmt(e)); end
         end
         n_vec++; if (drop_cnt !== 8'(m_drops)) begin n_err++; $display("FAIL rand_drop%0d: got %0d want %0d", i, drop_cnt, m_drops); end
      end
   endtask

   task automatic test_reset_in_req();
      move_t o, e;
      apply_reset();
      push(1, 2'b11, 1, 2'b00);
      game_tick = 1;
      @(negedge clk);
      game_tick = 0;
      for (int k = 0; k < 4 && !map_req; k++) @(negedge clk);
      n_vec++; if (map_req !== 1'b1) begin n_err++; $display("FAIL rreq_seen: got %b want 1", map_req); end
      #2 rst = 1'b0;
      #1;
      n_vec++; if (map_req !== 1'b0) begin n_err++; $display("FAIL rreq_req_drop: got %b want 0", map_req); end
      n_vec++; if (pac_x !== 10'd336 || pac_y !== 9'd240) begin n_err++; $display("FAIL rreq_pos: got %0d/%0d want 336/240", pac_x, pac_y); end
      n_vec++; if (map_addr !== 9'd0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL rreq_regs: got addr=%0d drop=%0d want 0/0", map_addr, drop_cnt); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      do_tick(2, 0, 0, 0, 0, 2'b00, o);
      e = model_tick(2, 0);
      n_vec++; if (o !== e) begin n_err++; $display("FAIL rreq_after: got %s want %s", fmt(o), fmt(e)); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      kp_valid = 0; kb_valid = 0; kp_dir = 0; kb_dir = 0;
      game_tick = 0; map_ack = 0; map_wall = 0;
      test_reset();
      test_right_move();
      test_left_edge();
      test_dual_source();
      test_overflow();
      test_full_pop_push();
      test_wall_delay();
      test_drop_saturate();
      test_random();
      test_reset_in_req();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
